scoreboard_register_file: RTL

- Responder end of the CPU register-file interface: services two combinational read ports and one write port.
- Adds a per-register pending scoreboard. The pipeline's issue stage reserves a destination register; the later writeback clears the reservation.
- Read results carry a valid flag, so the hazard logic can stall on an unresolved source register.
- Instantiated once per core, between decode/issue and writeback.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/scoreboard_pending.sv | 56 +++++
 rtl/scoreboard_register_file.sv | 87 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file types and constants for the core.
// Index and data widths derive from the architectural register count.
package cpu_pkg;

    localparam int NUM_REGS   = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);
    localparam int ZERO_REG   = 0;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/scoreboard_pending.sv
// Pending-bit scoreboard: reserve sets, writeback clears, reserve wins.
// Also tracks a sticky double-reserve flag and the pending popcount.
module scoreboard_pending #(
    parameter int NUM_REGS   = cpu_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reserve_valid,
    input  logic [ADDR_WIDTH-1:0] reserve_register,
    input  logic                  write_valid,
    input  logic [ADDR_WIDTH-1:0] write_register,
    output logic [NUM_REGS-1:0]   pending,
    output logic [ADDR_WIDTH:0]   pending_count,
    output logic                  reserve_conflict
);
    import cpu_pkg::*;

    logic                rsv_hit;
    logic                wr_hit;
    logic                conflict_now;
    logic [NUM_REGS-1:0] pending_next;

    always_comb begin
        rsv_hit = reserve_valid &&
                  (reserve_register != ADDR_WIDTH'(ZERO_REG));
        wr_hit  = write_valid &&
                  (write_register != ADDR_WIDTH'(ZERO_REG));
        pending_next = pending;
        if (wr_hit)
            pending_next[write_register] = 1'b0;
        // Set after clear: a newer producer owns the register.
        if (rsv_hit)
            pending_next[reserve_register] = 1'b1;
        conflict_now = rsv_hit && pending[reserve_register] &&
                       !(wr_hit && (write_register == reserve_register));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending          <= '0;
            reserve_conflict <= 1'b0;
        end else begin
            pending <= pending_next;
            if (conflict_now)
                reserve_conflict <= 1'b1;
        end
    end

    always_comb begin
        pending_count = '0;
        for (int i = 0; i < NUM_REGS; i++)
            pending_count += (ADDR_WIDTH+1)'(pending[i]);
    end

endmodule

// File: rtl/scoreboard_register_file.sv
// Register file with per-register pending scoreboard and valid-tagged reads.
// Define SCOREBOARD_BYPASS_EN to forward same-cycle writeback data to reads.
module scoreboard_register_file #(
    parameter int NUM_REGS   = cpu_pkg::NUM_REGS,
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_register_1,
    input  logic [ADDR_WIDTH-1:0] read_register_2,
    output logic [DATA_WIDTH-1:0] result_1,
    output logic [DATA_WIDTH-1:0] result_2,
    output logic                  result_1_valid,
    output logic                  result_2_valid,
    input  logic                  reserve_valid,
    input  logic [ADDR_WIDTH-1:0] reserve_register,
    input  logic                  write_valid,
    input  logic [ADDR_WIDTH-1:0] write_register,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [ADDR_WIDTH:0]   pending_count,
    output logic                  reserve_conflict
);
    import cpu_pkg::*;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   pending;
    logic [ADDR_WIDTH-1:0] raddr [2];
    logic [DATA_WIDTH-1:0] rdata [2];
    logic                  rvalid [2];
    logic                  wr_en;

    assign wr_en = write_valid &&
                   (write_register != ADDR_WIDTH'(ZERO_REG));

    scoreboard_pending #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_pending (
        .clk              (clk),
        .rst              (rst),
        .reserve_valid    (reserve_valid),
        .reserve_register (reserve_register),
        .write_valid      (write_valid),
        .write_register   (write_register),
        .pending          (pending),
        .pending_count    (pending_count),
        .reserve_conflict (reserve_conflict)
    );

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[write_register] <= write_data;
        end
    end

`ifdef SCOREBOARD_BYPASS_EN
    logic fwd;
    assign fwd = wr_en && !rst;
`endif

    always_comb begin
        raddr[0] = read_register_1;
        raddr[1] = read_register_2;
        for (int p = 0; p < 2; p++) begin
            rdata[p]  = regs[raddr[p]];
            rvalid[p] = !pending[raddr[p]];
`ifdef SCOREBOARD_BYPASS_EN
            if (fwd && (write_register == raddr[p])) begin
                rdata[p]  = write_data;
                rvalid[p] = !(reserve_valid &&
                              (reserve_register == raddr[p]));
            end
`endif
        end
    end

    assign result_1       = rdata[0];
    assign result_2       = rdata[1];
    assign result_1_valid = rvalid[0];
    assign result_2_valid = rvalid[1];

endmodule
